// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_HALT  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSN_NOP    = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } if_id_t;

    localparam if_id_t IF_ID_RESET = '{ins: 32'h0, pc: 32'h0, pc_plus4: 32'h4};

    // A fetch address is unusable if it is not word aligned or lies past the memory.
    function automatic logic pc_bad(input logic [31:0] pc, input logic [31:0] limit);
        return (pc[1:0] != 2'b00) || (pc >= limit);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID holding register with flush.
// Latency: one cycle from capture to presentation.
// Backpressure: contents held while hold_vld && !hold_rdy; flush beats capture and transfer.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush,
    input  logic   cap_vld,
    input  if_id_t cap_dat,
    output logic   hold_vld,
    input  logic   hold_rdy,
    output if_id_t hold_dat
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_vld <= 1'b0;
            hold_dat <= IF_ID_RESET;
        end else if (flush) begin
            hold_vld <= 1'b0;
        end else if (cap_vld) begin
            hold_vld <= 1'b1;
            hold_dat <= cap_dat;
        end else if (hold_rdy) begin
            hold_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC sequencing, redirect/flush, EBREAK halt and fetch fault.
// Latency: instruction appears on out_* one cycle after its address on imem_addr.
// Backpressure: out_ready=0 with out_valid=1 freezes pc and the IF/ID register.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ins,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] PC_LIMIT = 32'(MEM_SIZE * 4);

    state_t      state;
    logic [31:0] pc;
    logic        advance;
    logic        flush;
    logic        bad_pc;
    logic        capture;
    logic        xfer;
    if_id_t      cap_dat;
    if_id_t      hold_dat;

    assign imem_addr = pc;
    assign advance   = !out_valid || out_ready;
    // Faulted fetch ignores redirects, so it must not flush either.
    assign flush     = redirect_valid && (state != S_FAULT);
    assign bad_pc    = pc_bad(pc, PC_LIMIT);
    assign capture   = (state == S_RUN) && !redirect_valid && advance && !bad_pc;
    assign xfer      = out_valid && out_ready && !flush;

    assign cap_dat = '{ins: imem_rdata, pc: pc, pc_plus4: pc + 32'd4};

    if_id_reg u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .cap_vld  (capture),
        .cap_dat  (cap_dat),
        .hold_vld (out_valid),
        .hold_rdy (out_ready),
        .hold_dat (hold_dat)
    );

    assign out_ins      = hold_dat.ins;
    assign out_pc       = hold_dat.pc;
    assign out_pc_plus4 = hold_dat.pc_plus4;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_RUN;
            pc          <= RESET_PC;
            halted      <= 1'b0;
            fault       <= 1'b0;
            fetch_count <= 32'h0;
        end else begin
            if (xfer) begin
                fetch_count <= fetch_count + 32'd1;
            end
            case (state)
                S_RUN: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end else if (advance) begin
                        if (bad_pc) begin
                            state <= S_FAULT;
                            fault <= 1'b1;
                        end else begin
                            pc <= pc + 32'd4;
                            if (imem_rdata == INSN_EBREAK) begin
                                state  <= S_HALT;
                                halted <= 1'b1;
                            end
                        end
                    end
                end
                S_HALT: begin
                    if (redirect_valid) begin
                        pc     <= redirect_pc;
                        state  <= S_RUN;
                        halted <= 1'b0;
                    end
                end
                S_FAULT: begin
                    fault <= 1'b1;
                end
                default: begin
                    state <= S_FAULT;
                    fault <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-cycle vector table plus transfer scoreboard.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ins;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_count;

    logic [31:0] mem [1024];
    logic [31:0] sb [$];
    int total;
    int bad;

    assign imem_rdata = mem[imem_addr[11:2]];

    fetch_unit #(.RESET_PC(32'h0), .MEM_SIZE(1024)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_ins        (out_ins),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4),
        .halted         (halted),
        .fault          (fault),
        .fetch_count    (fetch_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eaddr;
        logic        eh;
        logic        ef;
        logic [31:0] efc;
    } vec_t;

    vec_t vecs [25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive inputs for the next edge; a transfer at that edge is scored against the queue.
    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
        logic [31:0] e;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (rst_n && out_valid && rdy && !rv) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", out_pc, 32'hDEAD_BEEF);
            end else begin
                e = sb.pop_front();
                chk("sb_pc", out_pc, e);
                chk("sb_ins", out_ins, mem[e[11:2]]);
                chk("sb_pc4", out_pc_plus4, e + 32'd4);
            end
        end
        @(negedge clk);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, {31'h0, out_valid}, 32'h0);
        chk({tag, "_ins"}, out_ins, 32'h0);
        chk({tag, "_pc"}, out_pc, 32'h0);
        chk({tag, "_pc4"}, out_pc_plus4, 32'h4);
        chk({tag, "_halted"}, {31'h0, halted}, 32'h0);
        chk({tag, "_fault"}, {31'h0, fault}, 32'h0);
        chk({tag, "_count"}, fetch_count, 32'h0);
        chk({tag, "_addr"}, imem_addr, 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;
    endtask

    function automatic vec_t v(input logic rdy, input logic rv, input logic [31:0] rpc,
                               input logic ev, input logic [31:0] epc, input logic [31:0] eaddr,
                               input logic eh, input logic ef, input logic [31:0] efc);
        vec_t r;
        r.rdy = rdy; r.rv = rv; r.rpc = rpc; r.ev = ev; r.epc = epc;
        r.eaddr = eaddr; r.eh = eh; r.ef = ef; r.efc = efc;
        return r;
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = {12'(i), 5'd0, 3'b000, 5'd1, 7'h13};
        end
        mem[4] = 32'h0010_0073;

        rst_n          = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_state("reset");
        rst_n = 1'b1;

        //          rdy   rv    rpc          ev    epc          addr         h     f     count
        vecs[0]  = v(1'b1, 1'b0, 32'h0,      1'b0, 32'h0,       32'h0,       1'b0, 1'b0, 32'd0);
        vecs[1]  = v(1'b1, 1'b0, 32'h0,      1'b1, 32'h0,       32'h4,       1'b0, 1'b0, 32'd0);
        vecs[2]  = v(1'b0, 1'b0, 32'h0,      1'b1, 32'h4,       32'h8,       1'b0, 1'b0, 32'd1);
        vecs[3]  = v(1'b0, 1'b0, 32'h0,      1'b1, 32'h4,       32'h8,       1'b0, 1'b0, 32'd1);
        vecs[4]  = v(1'b0, 1'b0, 32'h0,      1'b1, 32'h4,       32'h8,       1'b0, 1'b0, 32'd1);
        vecs[5]  = v(1'b1, 1'b0, 32'h0,      1'b1, 32'h4,       32'h8,       1'b0, 1'b0, 32'd1);
        vecs[6]  = v(1'b1, 1'b1, 32'h100,    1'b1, 32'h8,       32'hC,       1'b0, 1'b0, 32'd2);
        vecs[7]  = v(1'b1, 1'b0, 32'h0,      1'b0, 32'h0,       32'h100,     1'b0, 1'b0, 32'd2);
        vecs[8]  = v(1'b1, 1'b0, 32'h0,      1'b1, 32'h100,     32'h104,     1'b0, 1'b0, 32'd2);
        vecs[9]  = v(1'b0, 1'b1, 32'h8,      1'b1, 32'h104,     32'h108,     1'b0, 1'b0, 32'd3);
        vecs[10] = v(1'b1, 1'b0, 32'h0,      1'b0, 32'h0,       32'h8,       1'b0, 1'b0, 32'd3);
        vecs[11] = v(1'b1, 1'b0, 32'h0,      1'b1, 32'h8,       32'hC,       1'b0, 1'b0, 32'd3);
        vecs[12] = v(1'b1, 1'b0, 32'h0,      1'b1, 32'hC,       32'h10,      1'b0, 1'b0, 32'd4);
        vecs[13] = v(1'b0, 1'b0, 32'h0,      1'b1, 32'h10,      32'h14,      1'b1, 1'b0, 32'd5);
        vecs[14] = v(1'b1, 1'b0, 32'h0,      1'b1, 32'h10,      32'h14,      1'b1, 1'b0, 32'd5);
        vecs[15] = v(1'b1, 1'b0, 32'h0,      1'b0, 32'h0,       32'h14,      1'b1, 1'b0, 32'd6);
        vecs[16] = v(1'b1, 1'b1, 32'h0,      1'b0, 32'h0,       32'h14,      1'b1, 1'b0, 32'd6);
        vecs[17] = v(1'b1, 1'b0, 32'h0,      1'b0, 32'h0,       32'h0,       1'b0, 1'b0, 32'd6);
        vecs[18] = v(1'b1, 1'b0, 32'h0,      1'b1, 32'h0,       32'h4,       1'b0, 1'b0, 32'd6);
        vecs[19] = v(1'b1, 1'b1, 32'hFF8,    1'b1, 32'h4,       32'h8,       1'b0, 1'b0, 32'd7);
        vecs[20] = v(1'b1, 1'b0, 32'h0,      1'b0, 32'h0,       32'hFF8,     1'b0, 1'b0, 32'd7);
        vecs[21] = v(1'b1, 1'b0, 32'h0,      1'b1, 32'hFF8,     32'hFFC,     1'b0, 1'b0, 32'd7);
        vecs[22] = v(1'b1, 1'b0, 32'h0,      1'b1, 32'hFFC,     32'h1000,    1'b0, 1'b0, 32'd8);
        vecs[23] = v(1'b1, 1'b1, 32'h0,      1'b0, 32'h0,       32'h1000,    1'b0, 1'b1, 32'd9);
        vecs[24] = v(1'b1, 1'b0, 32'h0,      1'b0, 32'h0,       32'h1000,    1'b0, 1'b1, 32'd9);

        // Instructions that must reach decode, in order; flushed ones are absent.
        sb.push_back(32'h0);    sb.push_back(32'h4);   sb.push_back(32'h100);
        sb.push_back(32'h8);    sb.push_back(32'hC);   sb.push_back(32'h10);
        sb.push_back(32'h0);    sb.push_back(32'hFF8); sb.push_back(32'hFFC);

        for (int i = 0; i < 25; i++) begin
            chk($sformatf("v%0d_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].ev});
            if (vecs[i].ev) begin
                chk($sformatf("v%0d_pc", i), out_pc, vecs[i].epc);
            end
            chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].eaddr);
            chk($sformatf("v%0d_halted", i), {31'h0, halted}, {31'h0, vecs[i].eh});
            chk($sformatf("v%0d_fault", i), {31'h0, fault}, {31'h0, vecs[i].ef});
            chk($sformatf("v%0d_count", i), fetch_count, vecs[i].efc);
            step(vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
        end
        chk("sb_left_table", 32'(sb.size()), 32'd0);

        // Reset clears a sticky fault.
        do_reset();
        chk_reset_state("rst_fault");

        // Mid-operation reset during backpressure with a redirect pending.
        sb.push_back(32'h0);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        chk("bp_count", fetch_count, 32'd1);
        chk("bp_pc", out_pc, 32'h4);
        step(1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        step(1'b0, 1'b1, 32'h200);
        rst_n = 1'b1;
        chk_reset_state("rst_mid");
        step(1'b1, 1'b0, 32'h0);
        chk("post_rst_valid", {31'h0, out_valid}, 32'h1);
        chk("post_rst_pc", out_pc, 32'h0);

        // Misaligned redirect: loaded, then faults on the next fetch attempt.
        step(1'b1, 1'b1, 32'h102);
        chk("mis_valid0", {31'h0, out_valid}, 32'h0);
        chk("mis_addr", imem_addr, 32'h102);
        chk("mis_fault0", {31'h0, fault}, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        chk("mis_valid1", {31'h0, out_valid}, 32'h0);
        chk("mis_fault1", {31'h0, fault}, 32'h1);
        step(1'b1, 1'b0, 32'h0);
        chk("mis_valid2", {31'h0, out_valid}, 32'h0);
        chk("mis_count", fetch_count, 32'd0);
        chk("sb_left_end", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Fetch-stage initiator that drives byte addresses into the per-core instruction memory and registers the returned instruction into an IF/ID output register.
- The instruction memory read is combinational: word index is addr[11:2], data returns in the same cycle.
- Sits between the instruction memory and the decode stage of each core.
- Handles PC sequencing, branch/jump redirect with flush, valid/ready backpressure, EBREAK halt, and fault on misaligned or out-of-range PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- MEM_SIZE, 1024, instruction memory depth in 32-bit words; legal PC range is 0 to MEM_SIZE*4-4.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- imem_addr  output  32  byte address to instruction memory; equals the current pc register.
- imem_rdata  input  32  instruction at imem_addr, same cycle.
- redirect_valid  input  1  branch/jump taken; flush and load redirect_pc.
- redirect_pc  input  32  redirect target, byte address.
- out_valid  output  1  IF/ID register holds a valid instruction.
- out_ready  input  1  decode accepts the IF/ID contents this cycle.
- out_ins  output  32  fetched instruction.
- out_pc  output  32  address of out_ins.
- out_pc_plus4  output  32  out_pc + 4, for link-register use.
- halted  output  1  fetch stopped after EBREAK.
- fault  output  1  sticky misaligned or out-of-range fetch fault.
- fetch_count  output  32  number of instructions transferred to decode.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - pc=RESET_PC; out_valid=0; out_ins=0; out_pc=0; out_pc_plus4=4.
  - halted=0; fault=0; fetch_count=0; state=S_RUN.
  - Reset mid-operation discards any held instruction and any pending redirect.
- States:
  - S_RUN: normal fetch.
  - S_HALT: halted=1, no fetch.
  - S_FAULT: fault=1, no fetch, exited only by reset.
- advance = !out_valid || out_ready.
- Handshake:
  - A transfer occurs when out_valid && out_ready; fetch_count increments by 1 on each transfer, wrapping at 2^32.
  - While out_valid=1 and out_ready=0, out_ins, out_pc and out_pc_plus4 are held stable and pc does not change.
- S_RUN without redirect, when advance=1:
  - If pc[1:0]!=0 or pc >= MEM_SIZE*4: out_valid<=0, next state S_FAULT.
  - Otherwise: out_ins<=imem_rdata, out_pc<=pc, out_pc_plus4<=pc+4, out_valid<=1, pc<=pc+4.
  - If imem_rdata==32'h0010_0073 (EBREAK), the instruction is still captured and presented, and next state is S_HALT.
- Latency: an instruction appears on out_* one cycle after its address is presented on imem_addr. The sustained rate is one instruction per cycle when out_ready=1.
- Redirect:
  - Redirect has priority over every other event in S_RUN and S_HALT.
  - out_valid<=0, which flushes the IF/ID register even if out_ready=1 in the same cycle. The flushed instruction is not counted.
  - pc<=redirect_pc; no capture that cycle.
  - From S_HALT, a redirect returns to S_RUN and halted<=0.
  - A misaligned redirect_pc is loaded, then faults on the next fetch attempt.
  - Redirect is ignored in S_FAULT.
- S_HALT: out_valid drops when the EBREAK is accepted. pc holds at EBREAK address+4.
- Arithmetic: all PC math is 32-bit unsigned. pc+4 from 32'hFFFF_FFFC wraps to 0, but the range check faults before any such fetch.
- imem_addr is a pure combinational copy of pc, so the memory sees a stable address for the whole cycle.

Decomposition:
- Shared package fetch_pkg:
  - state encoding S_RUN=2'd0, S_HALT=2'd1, S_FAULT=2'd2.
  - constants INSN_EBREAK=32'h0010_0073 and INSN_NOP=32'h0000_0013.
  - IF/ID payload typedef {ins, pc, pc_plus4}.
- One natural sub-module: if_id_reg, the valid/ready holding register with flush. The PC/FSM logic stays in fetch_unit.

Test Plan:
- Sequential fetch:
  - Stimulus: imem preloaded with ADDI instructions at 0x0, 0x4, 0x8; out_ready=1.
  - Required: out_pc = 0x0, 0x4, 0x8 on consecutive cycles starting cycle 1 after reset release; fetch_count=3 after 3 transfers.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles while out_pc=0x4.
  - Required: out_ins/out_pc held and imem_addr stays 0x8; after release, 0x8 follows in the next cycle with no duplicate and no skip.
- Redirect:
  - Stimulus: redirect_valid=1, redirect_pc=0x100 while out_valid=1 and out_ready=1 at out_pc=0x8.
  - Required: next cycle out_valid=0; following cycle out_pc=0x100; the flushed 0x8 is not counted.
- EBREAK:
  - Stimulus: 32'h0010_0073 at 0x10.
  - Required: presented with out_pc=0x10; then out_valid=0, halted=1, imem_addr=0x14 held; redirect to 0x0 clears halted and resumes.
- Faults:
  - Misaligned: redirect_pc=0x102 -> fault=1 two cycles later and out_valid stays 0.
  - Out of range: with MEM_SIZE=1024, sequential fetch past 0xFFC -> fault=1 at pc=0x1000.
- Mid-operation reset:
  - Stimulus: rst_n=0 for one edge during backpressure.
  - Required: all outputs at reset values; pc=RESET_PC; fetch_count=0.
